// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: drives the RAM2 controller IF port and buffers
// completed words, tagged with their PC, in a first-word-fall-through queue for decode.
module inst_fetch_queue #(
    parameter int          ADDR_W   = 18,
    parameter int          DATA_W   = 16,
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [15:0]              redirect_pc,
    input  logic                     id_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_inst,
    output logic [15:0]              out_pc,
    output logic                     need_to_work_if,
    output logic [ADDR_W-1:0]        mem_addr_if,
    input  logic                     if_work_done_out,
    input  logic [DATA_W-1:0]        if_result,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              fetched_cnt
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [15:0]       r_fetch_pc;
    logic [15:0]       r_fetched_cnt;
    logic              r_settle;
    logic [DATA_W-1:0] r_inst_mem [DEPTH];
    logic [15:0]       r_pc_mem   [DEPTH];

    logic w_need;
    logic w_accept;
    logic w_pop;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_need   = !r_settle && (r_count != FULL_CNT);
        w_accept = w_need && if_work_done_out && !redirect_valid;
        w_pop    = (r_count != '0) && id_ready && !redirect_valid;
    end

    assign need_to_work_if = w_need;
    assign mem_addr_if     = ADDR_W'(r_fetch_pc);
    assign out_valid       = (r_count != '0);
    assign out_inst        = r_inst_mem[r_rd_ptr];
    assign out_pc          = r_pc_mem[r_rd_ptr];
    assign occupancy       = r_count;
    assign fetched_cnt     = r_fetched_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_fetch_pc    <= RESET_PC;
            r_fetched_cnt <= '0;
            r_settle      <= 1'b1;
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle completion or pop.
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= redirect_pc;
            r_settle   <= 1'b1;
        end else begin
            r_settle <= 1'b0;
            if (w_accept) begin
                r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
                r_fetch_pc    <= r_fetch_pc + 16'd1;
                r_fetched_cnt <= r_fetched_cnt + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: queue storage is not reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_inst_mem[r_wr_ptr] <= if_result;
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a small RAM2 controller model answers fetches,
// directed phases push expected {pc, inst} pairs and a monitor compares every delivered word.
module tb_inst_fetch_queue;

    localparam int          ADDR_W    = 18;
    localparam int          DATA_W    = 16;
    localparam int          DEPTH     = 4;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam int          DONE_LAT  = 3;

    logic                   clk;
    logic                   rst;
    logic                   redirect_valid;
    logic [15:0]            redirect_pc;
    logic                   id_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_inst;
    logic [15:0]            out_pc;
    logic                   need_to_work_if;
    logic [ADDR_W-1:0]      mem_addr_if;
    logic                   if_work_done_out;
    logic [DATA_W-1:0]      if_result;
    logic [$clog2(DEPTH):0] occupancy;
    logic [15:0]            fetched_cnt;

    inst_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .id_ready         (id_ready),
        .out_valid        (out_valid),
        .out_inst         (out_inst),
        .out_pc           (out_pc),
        .need_to_work_if  (need_to_work_if),
        .mem_addr_if      (mem_addr_if),
        .if_work_done_out (if_work_done_out),
        .if_result        (if_result),
        .occupancy        (occupancy),
        .fetched_cnt      (fetched_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb [$];
    exp_t        mon_e;
    logic        stall;
    logic [ADDR_W-1:0] last_addr;
    int          age;
    logic [15:0] fc;

    function automatic logic [15:0] word_of(input logic [15:0] pc);
        return pc + 16'h1000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: done rises DONE_LAT cycles after the address settles and stays
    // high while the address is unchanged (cached result); stall models EXE priority.
    initial begin
        last_addr        = '1;
        age              = 0;
        stall            = 1'b0;
        if_work_done_out = 1'b0;
        if_result        = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_addr_if !== last_addr) begin
                last_addr = mem_addr_if;
                age       = 0;
            end else if (age < 1000) begin
                age++;
            end
            if_work_done_out = (age >= DONE_LAT) && !stall;
            if_result        = word_of(last_addr[15:0]);
        end
    end

    // Monitor: a pop happens at the next rising edge whenever these hold at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && id_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got pc 0x%0h inst 0x%0h, expected no delivery", out_pc, out_inst);
            end else begin
                mon_e = sb.pop_front();
                check("pop_pc", 32'(out_pc), 32'(mon_e.pc));
                check("pop_inst", 32'(out_inst), 32'(mon_e.inst));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_range(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] p;
            p = start + 16'(i);
            sb.push_back('{pc: p, inst: word_of(p)});
        end
    endtask

    task automatic drain(input string name);
        id_ready = 1'b1;
        for (int i = 0; i < 300 && sb.size() != 0; i++) step();
        id_ready = 1'b0;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state, first cycle after reset.
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_need", 32'(need_to_work_if), 32'd0);
        check("rst_addr", 32'(mem_addr_if), 32'(RESET_PC));
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_fetched", 32'(fetched_cnt), 32'd0);
        step();
        check("settle_done_need", 32'(need_to_work_if), 32'd1);

        // Steady fetch: PCs 0..3 in order.
        push_range(RESET_PC, 4);
        drain("steady_drain");

        // Fill under backpressure, then drain with no skipped/duplicated PC.
        for (int i = 0; i < 200 && occupancy != 3'(DEPTH); i++) step();
        check("fill_occ", 32'(occupancy), 32'(DEPTH));
        check("fill_need", 32'(need_to_work_if), 32'd0);
        check("fill_addr", 32'(mem_addr_if), 32'h8);
        check("fill_fetched", 32'(fetched_cnt), 32'd8);
        repeat (5) step();
        check("full_hold_occ", 32'(occupancy), 32'(DEPTH));
        check("full_hold_addr", 32'(mem_addr_if), 32'h8);
        check("full_hold_need", 32'(need_to_work_if), 32'd0);
        push_range(16'h0004, 8);
        drain("refill_drain");

        // Redirect colliding with a completion and a pop.
        for (int i = 0; i < 200 && !(need_to_work_if && if_work_done_out && out_valid); i++) step();
        check("coll_arm_valid", 32'(out_valid), 32'd1);
        check("coll_arm_need", 32'(need_to_work_if), 32'd1);
        fc       = fetched_cnt;
        id_ready = 1'b1;
        do_redirect(16'h0040);
        id_ready = 1'b0;
        check("coll_occ", 32'(occupancy), 32'd0);
        check("coll_out_valid", 32'(out_valid), 32'd0);
        check("coll_need", 32'(need_to_work_if), 32'd0);
        check("coll_addr", 32'(mem_addr_if), 32'h40);
        check("coll_fetched", 32'(fetched_cnt), 32'(fc));
        push_range(16'h0040, 2);
        drain("coll_drain");

        // PC wrap across 16'hffff.
        do_redirect(16'hfffe);
        fc = fetched_cnt;
        for (int i = 0; i < 200 && occupancy != 3'd3; i++) step();
        check("wrap_occ", 32'(occupancy), 32'd3);
        check("wrap_fetched", 32'(fetched_cnt), 32'(fc + 16'd3));
        check("wrap_addr", 32'(mem_addr_if), 32'h1);
        push_range(16'hfffe, 3);
        drain("wrap_drain");

        // EXE-priority stall mid-stream.
        do_redirect(16'h0100);
        fc = fetched_cnt;
        push_range(16'h0100, 4);
        id_ready = 1'b1;
        for (int i = 0; i < 200 && fetched_cnt != fc + 16'd2; i++) step();
        check("stall_arm_fetched", 32'(fetched_cnt), 32'(fc + 16'd2));
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_need", 32'(need_to_work_if), 32'd1);
            check("stall_addr", 32'(mem_addr_if), 32'h102);
            check("stall_fetched", 32'(fetched_cnt), 32'(fc + 16'd2));
        end
        stall = 1'b0;
        drain("stall_drain");

        // Reset mid-operation with three entries and a completion pending.
        for (int i = 0; i < 200 && !(occupancy == 3'd3 && if_work_done_out && need_to_work_if); i++) step();
        check("mrst_arm_occ", 32'(occupancy), 32'd3);
        check("mrst_arm_need", 32'(need_to_work_if), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_occ", 32'(occupancy), 32'd0);
        check("mrst_fetched", 32'(fetched_cnt), 32'd0);
        check("mrst_addr", 32'(mem_addr_if), 32'(RESET_PC));
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_need", 32'(need_to_work_if), 32'd0);
        push_range(RESET_PC, 2);
        drain("mrst_drain");

        repeat (5) step();
        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
